// File: rtl/systolic_result_drain.sv
// Result drain for a 2x2 systolic array: buffers whole result matrices on a
// valid pulse and streams their elements out row-major over valid/ready.
module systolic_result_drain #(
    parameter int DW = 9,
    parameter int N  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   res_valid,
    input  logic [DW-1:0]          c11,
    input  logic [DW-1:0]          c12,
    input  logic [DW-1:0]          c21,
    input  logic [DW-1:0]          c22,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [DW-1:0]          m_data,
    output logic [1:0]             m_idx,
    output logic                   m_last,
    output logic                   full,
    output logic [$clog2(N+1)-1:0] count,
    output logic                   overflow,
    input  logic                   clr_overflow
);

    localparam int PW = $clog2(N);
    localparam int CW = $clog2(N+1);

    typedef enum logic {EMPTY, STREAM} state_t;

    logic [4*DW-1:0] mem [N];
    logic [4*DW-1:0] head;
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [1:0]      idx;
    logic [CW-1:0]   count_q, count_next;
    state_t          state, state_next;
    logic            beat, pop, wr_en, drop;

    assign full  = (count_q == CW'(N));
    assign count = count_q;
    assign beat  = m_valid && m_ready;
    assign pop   = beat && (idx == 2'd3);
    // A pop frees the head slot on the same edge, so a full buffer can still accept.
    assign wr_en = res_valid && (!full || pop);
    assign drop  = res_valid && full && !pop;
    assign head  = mem[rd_ptr];

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        count_next = count_q;
        case ({wr_en, pop})
            2'b10:   count_next = count_q + CW'(1);
            2'b01:   count_next = count_q - CW'(1);
            default: count_next = count_q;
        endcase
    end

    // NOTE: the buffer RAM has no reset; only the pointers and count define its contents.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= {c11, c12, c21, c22};
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            idx      <= '0;
            count_q  <= '0;
            overflow <= 1'b0;
        end else begin
            count_q <= count_next;
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            if (pop)   rd_ptr <= rd_ptr + PW'(1);
            if (beat)  idx    <= idx + 2'd1;
            if (drop)              overflow <= 1'b1;
            else if (clr_overflow) overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_next;
    end

    // Next state follows the post-edge count, so a write into an empty buffer is visible next cycle.
    always_comb begin
        state_next = state;
        case (state)
            EMPTY:   if (count_next != '0) state_next = STREAM;
            STREAM:  if (count_next == '0) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    always_comb begin
        m_valid = 1'b0;
        m_data  = '0;
        m_idx   = '0;
        m_last  = 1'b0;
        if (state == STREAM) begin
            m_valid = 1'b1;
            m_idx   = idx;
            m_last  = (idx == 2'd3);
            case (idx)
                2'd0:    m_data = head[4*DW-1 -: DW];
                2'd1:    m_data = head[3*DW-1 -: DW];
                2'd2:    m_data = head[2*DW-1 -: DW];
                default: m_data = head[DW-1:0];
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_result_drain.sv
// Scoreboard bench for systolic_result_drain: stimulus pushes expected beats,
// a negedge monitor pops and compares every accepted beat and every held beat.
module tb_systolic_result_drain;

    localparam int DW = 9;
    localparam int N  = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          res_valid = 1'b0;
    logic [DW-1:0] c11 = '0, c12 = '0, c21 = '0, c22 = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic [1:0]    m_idx;
    logic          m_last;
    logic          full;
    logic [1:0]    count;
    logic          overflow;
    logic          clr_overflow = 1'b0;

    systolic_result_drain #(.DW(DW), .N(N)) dut (
        .clk(clk), .rst_n(rst_n), .res_valid(res_valid),
        .c11(c11), .c12(c12), .c21(c21), .c22(c22),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_idx(m_idx), .m_last(m_last), .full(full), .count(count),
        .overflow(overflow), .clr_overflow(clr_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic [1:0]    idx;
        logic          last;
    } beat_t;

    beat_t exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    n_beats  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] a, b, c, d, input bit expect_out);
        c11 = a; c12 = b; c21 = c; c22 = d;
        res_valid = 1'b1;
        if (expect_out) begin
            exp_q.push_back('{a, 2'd0, 1'b0});
            exp_q.push_back('{b, 2'd1, 1'b0});
            exp_q.push_back('{c, 2'd2, 1'b0});
            exp_q.push_back('{d, 2'd3, 1'b1});
        end
        tick();
        res_valid = 1'b0;
    endtask

    // Monitor: scoreboard compare on every transfer, stability check on every stall.
    initial begin
        beat_t         e;
        bit            hold = 1'b0;
        logic [DW-1:0] h_data;
        logic [1:0]    h_idx;
        logic          h_last;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    check("hold_valid", m_valid, 1);
                    check("hold_data", m_data, h_data);
                    check("hold_idx", m_idx, h_idx);
                    check("hold_last", m_last, h_last);
                end
                hold = m_valid && !m_ready;
                h_data = m_data; h_idx = m_idx; h_last = m_last;
                if (m_valid && m_ready) begin
                    n_beats++;
                    if (exp_q.size() == 0) begin
                        check("spurious_beat_data", m_data, 0);
                        n_fail += (m_data == 0) ? 1 : 0;
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_data", m_data, e.data);
                        check("beat_idx", m_idx, e.idx);
                        check("beat_last", m_last, e.last);
                    end
                end
            end
        end
    end

    initial begin
        bit pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        int b0;

        // Reset state
        tick(); tick();
        check("rst_m_valid", m_valid, 0);
        check("rst_count", count, 0);
        check("rst_full", full, 0);
        check("rst_overflow", overflow, 0);
        check("rst_m_data", m_data, 0);
        check("rst_m_idx", m_idx, 0);
        check("rst_m_last", m_last, 0);
        rst_n = 1'b1;
        tick();

        // Single matrix, sink always ready
        m_ready = 1'b1;
        b0 = n_beats;
        send(9'd19, 9'd22, 9'd43, 9'd50, 1);
        check("t1_valid_latency", m_valid, 1);
        check("t1_first_idx", m_idx, 0);
        check("t1_first_data", m_data, 19);
        check("t1_count_1", count, 1);
        repeat (4) tick();
        check("t1_beats", n_beats - b0, 4);
        check("t1_valid_fall", m_valid, 0);
        check("t1_count_0", count, 0);

        // Back-pressure pattern
        m_ready = 1'b0;
        b0 = n_beats;
        send(9'd19, 9'd22, 9'd43, 9'd50, 1);
        for (int i = 0; i < 7; i++) begin
            m_ready = pat[i];
            tick();
        end
        check("t2_beats", n_beats - b0, 4);
        check("t2_valid_fall", m_valid, 0);

        // Fill, overflow with simultaneous clear (set wins), then clear alone
        m_ready = 1'b0;
        send(9'd1, 9'd2, 9'd3, 9'd4, 1);
        send(9'h1FF, 9'h100, 9'd5, 9'd6, 1);
        check("t3_full", full, 1);
        check("t3_count", count, 2);
        check("t3_ovf_before", overflow, 0);
        clr_overflow = 1'b1;
        send(9'd7, 9'd7, 9'd7, 9'd7, 0);
        clr_overflow = 1'b0;
        check("t3_ovf_set_wins", overflow, 1);
        check("t3_count_after_drop", count, 2);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        check("t3_ovf_cleared", overflow, 0);
        m_ready = 1'b1;
        b0 = n_beats;
        repeat (8) tick();
        check("t3_beats_no_bubble", n_beats - b0, 8);
        check("t3_valid_fall", m_valid, 0);

        // Pop and write in the same cycle while full
        m_ready = 1'b0;
        send(9'd11, 9'd12, 9'd13, 9'd14, 1);
        send(9'd21, 9'd22, 9'd23, 9'd24, 1);
        m_ready = 1'b1;
        repeat (3) tick();
        check("t4_head_idx3", m_idx, 3);
        check("t4_count_full", count, 2);
        send(9'd31, 9'd32, 9'd33, 9'd34, 1);
        check("t4_count_stays", count, 2);
        check("t4_ovf_stays", overflow, 0);
        check("t4_next_idx0", m_idx, 0);
        check("t4_next_data", m_data, 21);
        repeat (8) tick();
        check("t4_drained", m_valid, 0);
        check("t4_count_0", count, 0);

        // Reset mid-stream
        m_ready = 1'b0;
        send(9'd41, 9'd42, 9'd43, 9'd44, 1);
        send(9'd51, 9'd52, 9'd53, 9'd54, 1);
        send(9'd61, 9'd62, 9'd63, 9'd64, 0);
        m_ready = 1'b1;
        repeat (2) tick();
        m_ready = 1'b0;
        check("t6_pre_idx", m_idx, 2);
        check("t6_pre_count", count, 2);
        check("t6_pre_ovf", overflow, 1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", m_valid, 0);
        check("t6_rst_count", count, 0);
        check("t6_rst_ovf", overflow, 0);
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        m_ready = 1'b1;
        b0 = n_beats;
        send(9'd71, 9'd72, 9'd73, 9'd74, 1);
        check("t6_restart_idx", m_idx, 0);
        check("t6_restart_data", m_data, 71);
        repeat (4) tick();
        check("t6_beats", n_beats - b0, 4);
        check("t6_drained", m_valid, 0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/systolic_result_drain.md
Name: systolic_result_drain

Overview:
- Consumer-side end of the systolic controller's result interface.
- Captures each 2×2 result matrix (c11..c22) on its single-cycle valid pulse into an N-entry buffer.
- Streams the buffered elements out one per beat, row-major, over a valid/ready handshake with index and last markers.
- Sits between the systolic array controller and any downstream sink (bus writer, UART, scoreboard); isolates the controller, which has no back-pressure, from a slow sink.

Parameters:
- DW, 9, width of one result element (4+4+1 for 4-bit operands).
- N, 2, buffer depth in whole matrices; power of two, N >= 2.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- res_valid  input  1  single-cycle pulse: c11..c22 hold one complete result matrix.
- c11  input  DW  result element row 1, col 1.
- c12  input  DW  result element row 1, col 2.
- c21  input  DW  result element row 2, col 1.
- c22  input  DW  result element row 2, col 2.
- m_valid  output  1  m_data / m_idx / m_last are valid.
- m_ready  input  1  sink accepts the current beat.
- m_data  output  DW  current element.
- m_idx  output  2  element index: 0=c11, 1=c12, 2=c21, 3=c22.
- m_last  output  1  high on the idx 3 beat of a matrix.
- full  output  1  count == N.
- count  output  $clog2(N+1)  matrices held, including a partially drained head.
- overflow  output  1  sticky: a result was dropped.
- clr_overflow  input  1  synchronous clear of overflow.

Behaviour:
- Reset (async assert, sync release): count=0, read/write pointers=0, element index=0, overflow=0; m_valid=0, m_last=0, full=0. m_data and m_idx read as 0 while m_valid=0. Buffer RAM contents are not reset.
- Storage: N entries of 4*DW bits, packed {c11,c12,c21,c22}; write and read pointers wrap modulo N.
- Write acceptance: res_valid && (count < N || pop this cycle). An accepted matrix is stored at wr_ptr on the same edge, and wr_ptr advances.
- pop = m_valid && m_ready && idx==3.
- Latency: res_valid at edge t with an empty buffer gives m_valid=1, m_idx=0, m_data=c11 in the cycle after edge t. There is no combinational path from res_valid to m_valid.
- Two-state FSM per head entry:
  - EMPTY: m_valid=0; go to STREAM when count becomes nonzero.
  - STREAM: m_valid=1; m_data = head element selected by idx; m_last = (idx==3).
  - In STREAM, each m_valid&&m_ready beat increments idx. On idx==3 acceptance: idx←0, rd_ptr advances, count decrements.
  - After the pop, stay in STREAM if another entry remains (the next matrix's c11 is presented in the very next cycle, no bubble); otherwise go to EMPTY.
- Hold rule: while m_valid && !m_ready, m_data, m_idx and m_last stay stable. A concurrent write never disturbs the head entry.
- Count update: write-only +1, pop-only −1, write and pop together unchanged.
- Full with pop: when count==N and a pop occurs in the same cycle as res_valid, the new matrix is accepted and count stays N.
- Overflow: res_valid while count==N with no pop → matrix dropped; the buffer, count and pointers are unchanged, and overflow←1 on that edge.
- Overflow clear: clr_overflow alone → overflow←0. A drop and clr_overflow in the same cycle → overflow←1 (set wins).
- res_valid held high for multiple cycles: each cycle is a distinct matrix, subject to the same acceptance rule.
- Reset mid-stream: all buffered and partially drained matrices are discarded. m_valid falls to 0 immediately on rst_n assertion, and idx restarts at 0 after release.
- Widths: data is passed through unmodified, with no arithmetic on elements. count saturates logically at N, never wraps.

Test Plan:
- Single matrix, m_ready=1: reset, one res_valid pulse with c11=9'd19, c12=9'd22, c21=9'd43, c22=9'd50 → m_valid rises the next cycle; 4 consecutive beats 19, 22, 43, 50 with m_idx 0..3; m_last only on 50; count 1→0; m_valid falls after the last beat.
- Back-pressure: same matrix, m_ready toggled 1,0,0,1,0,1,1 → beats delivered in order; m_data/m_idx held unchanged during every m_ready=0 cycle; exactly 4 transfers.
- Full and overflow, N=2, m_ready=0: three res_valid pulses carrying matrices M0, M1, M2 → full=1 and count=2 after the second; overflow=1 after the third. Drive m_ready=1 → 8 beats of M0 then M1, no bubble between M0's last beat and M1's c11; M2 never appears.
- Simultaneous pop and write at full: count=2, head at idx 3, m_ready=1, res_valid with M3 in the same cycle → M3 accepted, count stays 2, overflow stays 0, M3 streamed after M1.
- Overflow clear precedence: clr_overflow and a dropping res_valid in the same cycle → overflow=1. clr_overflow alone on a later cycle → overflow=0.
- Reset mid-stream: assert rst_n low while at m_idx=2 of a matrix with count=2 → m_valid=0, count=0, overflow=0 immediately. After release, a new matrix streams starting at m_idx=0.
